// File: rtl/timer_pkg.sv
// Shared types, digit limits and preset clamping for the BCD countdown timer.
package timer_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned CNT_W      = DIGIT_W * NUM_DIGITS;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX_TENS  = 4'd5;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX_UNITS = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    // Digit 0 is 10ms; digits 3 (10s) and 5 (10m) are base-6.
    function automatic logic [DIGIT_W-1:0] digit_max(input int unsigned idx);
        return (idx == 3 || idx == 5) ? DIGIT_MAX_TENS : DIGIT_MAX_UNITS;
    endfunction

    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                       input logic [DIGIT_W-1:0] max);
        return (d > max) ? max : d;
    endfunction

    function automatic logic [CNT_W-1:0] clamp_preset(input logic [CNT_W-1:0] p);
        logic [CNT_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            r[i*DIGIT_W +: DIGIT_W] = clamp_digit(p[i*DIGIT_W +: DIGIT_W], digit_max(i));
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps to MAX on borrow and passes the borrow upward.
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = DIGIT_MAX_UNITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_data,
    input  logic               borrow_in,
    input  logic               dec_en,
    output logic [DIGIT_W-1:0] digit,
    output logic               borrow_out_c,
    output logic               is_zero_c
);

    assign is_zero_c    = (digit == '0);
    assign borrow_out_c = borrow_in && is_zero_c;

    // Digit register: load wins over decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit <= '0;
        end else if (load) begin
            digit <= load_data;
        end else if (dec_en && borrow_in) begin
            digit <= is_zero_c ? MAX : digit - DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// mm:ss.cc countdown timer: FSM, prescaler, alarm hold counter and reload register.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 500000,
    parameter int unsigned TICK_W     = 19,
    parameter int unsigned ALARM_HOLD = 100
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iLOAD,
    input  logic [CNT_W-1:0] iPRESET,
    input  logic             iSTART,
    input  logic             iSTOP,
    input  logic             iMODE,
    output logic [CNT_W-1:0] oCNT,
    output logic             oRUN,
    output logic             oDONE,
    output logic             oALARM
);

    localparam int unsigned ALARM_W = (ALARM_HOLD < 2) ? 1 : $clog2(ALARM_HOLD + 1);

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  pre_q, pre_d;
    logic [ALARM_W-1:0] alarm_cnt_q, alarm_cnt_d;
    logic [CNT_W-1:0]   reload_q, reload_d;
    logic               pend_q, pend_d;
    logic               run_q, done_q, done_d, alarm_q;

    logic [CNT_W-1:0]      cnt;
    logic [NUM_DIGITS:0]   borrow_c;
    logic [NUM_DIGITS-1:0] is_zero_c;
    logic                  dig_load_c, dig_dec_c;
    logic [CNT_W-1:0]      dig_data_c;
    logic                  counting_c, tick_c, cnt_zero_c, cnt_one_c;

    // Borrow chain from 10ms up to 10m; a borrow out of the top means every digit is zero.
    assign borrow_c[0] = 1'b1;
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_down_digit #(
            .MAX((i == 3 || i == 5) ? DIGIT_MAX_TENS : DIGIT_MAX_UNITS)
        ) u_digit (
            .clk         (iCLK),
            .rst         (iRST),
            .load        (dig_load_c),
            .load_data   (dig_data_c[i*DIGIT_W +: DIGIT_W]),
            .borrow_in   (borrow_c[i]),
            .dec_en      (dig_dec_c),
            .digit       (cnt[i*DIGIT_W +: DIGIT_W]),
            .borrow_out_c(borrow_c[i+1]),
            .is_zero_c   (is_zero_c[i])
        );
    end

    assign cnt_zero_c = borrow_c[NUM_DIGITS];
    assign cnt_one_c  = (cnt[DIGIT_W-1:0] == DIGIT_W'(1)) && (&is_zero_c[NUM_DIGITS-1:1]);
    assign counting_c = (state_q == ST_RUN) || (state_q == ST_ALARM && alarm_cnt_q != '0);
    assign tick_c     = counting_c && (pre_q == TICK_W'(TICK_DIV - 1));

    assign oCNT   = cnt;
    assign oRUN   = run_q;
    assign oDONE  = done_q;
    assign oALARM = alarm_q;

    // State and datapath registers.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= ST_IDLE;
            pre_q       <= '0;
            alarm_cnt_q <= '0;
            reload_q    <= '0;
            pend_q      <= 1'b0;
            run_q       <= 1'b0;
            done_q      <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            alarm_cnt_q <= alarm_cnt_d;
            reload_q    <= reload_d;
            pend_q      <= pend_d;
            run_q       <= (state_d == ST_RUN);
            done_q      <= done_d;
            alarm_q     <= (alarm_cnt_d != '0);
        end
    end

    // Next-state, prescaler, alarm and digit control.
    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        alarm_cnt_d = alarm_cnt_q;
        reload_d    = reload_q;
        pend_d      = pend_q;
        done_d      = 1'b0;
        dig_load_c  = 1'b0;
        dig_dec_c   = 1'b0;
        dig_data_c  = reload_q;

        if (counting_c) begin
            pre_d = tick_c ? '0 : pre_q + TICK_W'(1);
        end
        if (tick_c && alarm_cnt_q != '0) begin
            alarm_cnt_d = alarm_cnt_q - ALARM_W'(1);
        end

        if (iLOAD) begin
            dig_load_c  = 1'b1;
            dig_data_c  = clamp_preset(iPRESET);
            reload_d    = clamp_preset(iPRESET);
            pre_d       = '0;
            alarm_cnt_d = '0;
            pend_d      = 1'b0;
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!iSTOP && iSTART && !cnt_zero_c) state_d = ST_RUN;
                end
                ST_PAUSE: begin
                    if (!iSTOP && iSTART) state_d = ST_RUN;
                end
                ST_RUN: begin
                    // The prescaler still advances on the pausing edge so resume timing is exact.
                    if (tick_c) begin
                        if (pend_q) begin
                            dig_load_c = 1'b1;
                            pend_d     = 1'b0;
                        end else if (cnt_one_c) begin
                            dig_dec_c   = 1'b1;
                            done_d      = 1'b1;
                            alarm_cnt_d = ALARM_W'(ALARM_HOLD);
                            if (iMODE && reload_q != '0) pend_d  = 1'b1;
                            else                         state_d = ST_ALARM;
                        end else begin
                            dig_dec_c = 1'b1;
                        end
                    end
                    if (iSTOP && state_d == ST_RUN) state_d = ST_PAUSE;
                end
                ST_ALARM: begin
                    if (iSTOP) begin
                        alarm_cnt_d = '0;
                        state_d     = ST_IDLE;
                    end else if (alarm_cnt_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with TICK_DIV = 4, ALARM_HOLD = 3.
module tb_bcd_countdown_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [23:0] preset = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode = 1'b0;
    logic [23:0] cnt;
    logic        run, done, alarm;

    int n_vec = 0;
    int n_err = 0;

    bcd_countdown_timer #(
        .TICK_DIV  (4),
        .TICK_W    (3),
        .ALARM_HOLD(3)
    ) dut (
        .iCLK   (clk),
        .iRST   (rst),
        .iLOAD  (load),
        .iPRESET(preset),
        .iSTART (start),
        .iSTOP  (stop),
        .iMODE  (mode),
        .oCNT   (cnt),
        .oRUN   (run),
        .oDONE  (done),
        .oALARM (alarm)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [23:0] p);
        load = 1'b1; preset = p;
        step(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    int done_n, alarm_n;
    logic [23:0] ar_exp [6];

    initial begin
        ar_exp[0] = 24'h000001; ar_exp[1] = 24'h000000; ar_exp[2] = 24'h000002;
        ar_exp[3] = 24'h000001; ar_exp[4] = 24'h000000; ar_exp[5] = 24'h000002;

        // Reset
        step(2);
        rst = 1'b0;
        check_eq("rst_cnt", cnt, 24'h0);
        check_eq("rst_run", run, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_alarm", alarm, 1'b0);

        // One-shot from 3
        do_load(24'h000003);
        check_eq("os_load", cnt, 24'h000003);
        do_start();
        check_eq("os_run", run, 1'b1);
        done_n = 0; alarm_n = 0;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            done_n  += int'(done);
            alarm_n += int'(alarm);
            if (k == 3)  check_eq("os_k3", cnt, 24'h000003);
            if (k == 4)  check_eq("os_k4", cnt, 24'h000002);
            if (k == 8)  check_eq("os_k8", cnt, 24'h000001);
            if (k == 12) begin
                check_eq("os_k12_cnt", cnt, 24'h000000);
                check_eq("os_k12_done", done, 1'b1);
                check_eq("os_k12_alarm", alarm, 1'b1);
                check_eq("os_k12_run", run, 1'b0);
            end
            if (k == 23) check_eq("os_k23_alarm", alarm, 1'b1);
            if (k == 24) check_eq("os_k24_alarm", alarm, 1'b0);
        end
        check_eq("os_done_pulses", done_n, 1);
        check_eq("os_alarm_cycles", alarm_n, 12);
        check_eq("os_end_run", run, 1'b0);

        // Borrow chain, then zero start ignored
        do_load(24'h010000);
        do_start();
        step(3);
        check_eq("br_k3", cnt, 24'h010000);
        step(1);
        check_eq("br_k4", cnt, 24'h005999);
        do_load(24'h000000);
        do_start();
        check_eq("zero_start_run", run, 1'b0);
        step(5);
        check_eq("zero_start_cnt", cnt, 24'h0);
        check_eq("zero_start_run2", run, 1'b0);

        // Clamp
        do_load(24'h9F9F9F);
        check_eq("clamp_cnt", cnt, 24'h595999);
        check_eq("clamp_reload", dut.reload_q, 24'h595999);

        // Pause / resume timing
        do_load(24'h000005);
        do_start();
        step(5);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_eq("pause_run", run, 1'b0);
        check_eq("pause_cnt", cnt, 24'h000004);
        step(20);
        check_eq("pause_hold", cnt, 24'h000004);
        do_start();
        check_eq("resume_run", run, 1'b1);
        step(1);
        check_eq("resume_r1", cnt, 24'h000004);
        step(1);
        check_eq("resume_r2", cnt, 24'h000003);

        // Auto-reload
        mode = 1'b1;
        do_load(24'h000002);
        do_start();
        done_n = 0;
        for (int k = 1; k <= 24; k++) begin
            step(1);
            done_n += int'(done);
            if (k % 4 == 0) begin
                check_eq($sformatf("ar_cnt_k%0d", k), cnt, ar_exp[k/4 - 1]);
                check_eq($sformatf("ar_run_k%0d", k), run, 1'b1);
                check_eq($sformatf("ar_done_k%0d", k), done, (k == 8 || k == 20) ? 1'b1 : 1'b0);
            end
            if (k == 4)  check_eq("ar_alarm_k4", alarm, 1'b0);
            if (k == 12) check_eq("ar_alarm_k12", alarm, 1'b1);
            if (k == 21) check_eq("ar_alarm_k21", alarm, 1'b1);
        end
        check_eq("ar_done_pulses", done_n, 2);

        // Load together with start
        load = 1'b1; start = 1'b1; preset = 24'h000007;
        step(1);
        load = 1'b0; start = 1'b0;
        check_eq("ls_cnt", cnt, 24'h000007);
        check_eq("ls_run", run, 1'b0);
        check_eq("ls_alarm", alarm, 1'b0);
        step(8);
        check_eq("ls_idle_cnt", cnt, 24'h000007);

        // Stop during alarm
        mode = 1'b0;
        do_load(24'h000001);
        do_start();
        step(4);
        check_eq("sa_done", done, 1'b1);
        check_eq("sa_alarm_on", alarm, 1'b1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_eq("sa_alarm_off", alarm, 1'b0);
        check_eq("sa_run", run, 1'b0);

        // Reset during run
        do_load(24'h000009);
        do_start();
        step(5);
        check_eq("rr_pre", cnt, 24'h000008);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_eq("rr_cnt", cnt, 24'h0);
        check_eq("rr_run", run, 1'b0);
        check_eq("rr_done", done, 1'b0);
        check_eq("rr_alarm", alarm, 1'b0);
        check_eq("rr_reload", dut.reload_q, 24'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
